// File: rtl/memory_wishbone_arbiter.sv
// rtl/memory_wishbone_arbiter.sv - round-robin arbiter sharing one L2 wishbone slave between I- and D-cache masters
module memory_wishbone_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 12,
    parameter int SEL_WIDTH  = 16,
    parameter int TIMEOUT    = 255,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_cyc,
    input  logic                  i_stb,
    input  logic                  i_we,
    input  logic [SEL_WIDTH-1:0]  i_sel,
    input  logic [ADDR_WIDTH-1:0] i_adr,
    input  logic [DATA_WIDTH-1:0] i_dat_m,
    output logic [DATA_WIDTH-1:0] i_dat_s,
    output logic                  i_ack,
    output logic                  i_rty,
    input  logic                  d_cyc,
    input  logic                  d_stb,
    input  logic                  d_we,
    input  logic [SEL_WIDTH-1:0]  d_sel,
    input  logic [ADDR_WIDTH-1:0] d_adr,
    input  logic [DATA_WIDTH-1:0] d_dat_m,
    output logic [DATA_WIDTH-1:0] d_dat_s,
    output logic                  d_ack,
    output logic                  d_rty,
    output logic                  s_cyc,
    output logic                  s_stb,
    output logic                  s_we,
    output logic [SEL_WIDTH-1:0]  s_sel,
    output logic [ADDR_WIDTH-1:0] s_adr,
    output logic [DATA_WIDTH-1:0] s_dat_m,
    input  logic [DATA_WIDTH-1:0] s_dat_s,
    input  logic                  s_ack,
    input  logic                  s_rty,
    output logic                  grant_i,
    output logic                  grant_d,
    output logic                  timeout_err,
    output logic [CNT_WIDTH-1:0]  i_grant_count,
    output logic [CNT_WIDTH-1:0]  d_grant_count
);

    localparam int              WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
    localparam bit              WD_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                last_d;
    logic [WD_W-1:0]     wdog;
    logic                req_i;
    logic                req_d;
    logic                busy_i;
    logic                busy_d;
    logic                busy;
    logic                expire;
    logic                own_cyc;
    logic                own_stb;
    logic                own_we;
    logic [SEL_WIDTH-1:0]  own_sel;
    logic [ADDR_WIDTH-1:0] own_adr;
    logic [DATA_WIDTH-1:0] own_dat;

    always_comb begin
        req_i   = i_cyc & i_stb;
        req_d   = d_cyc & d_stb;
        busy_i  = (state == BUSY_I);
        busy_d  = (state == BUSY_D);
        busy    = busy_i | busy_d;
        own_cyc = busy_i ? i_cyc   : d_cyc;
        own_stb = busy_i ? i_stb   : d_stb;
        own_we  = busy_i ? i_we    : d_we;
        own_sel = busy_i ? i_sel   : d_sel;
        own_adr = busy_i ? i_adr   : d_adr;
        own_dat = busy_i ? i_dat_m : d_dat_m;
        // An ack or retry in the expiry cycle is a normal completion, not a timeout.
        expire  = WD_EN && busy && (wdog == WD_LIMIT) && !s_ack && !s_rty;
    end

    always_comb begin
        s_cyc       = busy & own_cyc & ~expire;
        s_stb       = busy & own_stb & ~expire;
        s_we        = busy & own_we;
        s_sel       = busy ? own_sel : '0;
        s_adr       = busy ? own_adr : '0;
        s_dat_m     = busy ? own_dat : '0;
        i_dat_s     = s_dat_s;
        d_dat_s     = s_dat_s;
        i_ack       = busy_i & s_ack;
        i_rty       = busy_i & (s_rty | expire);
        d_ack       = busy_d & s_ack;
        d_rty       = busy_d & (s_rty | expire);
        grant_i     = busy_i;
        grant_d     = busy_d;
        timeout_err = expire;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                // On a tie, the master that did not win last time takes the slave.
                if (req_i && (!req_d || last_d)) begin
                    state_next = BUSY_I;
                end else if (req_d) begin
                    state_next = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (!own_cyc || s_ack || s_rty || expire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            last_d        <= 1'b0;
            wdog          <= '0;
            i_grant_count <= '0;
            d_grant_count <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == BUSY_I) begin
                last_d        <= 1'b0;
                i_grant_count <= i_grant_count + CNT_WIDTH'(1);
            end
            if (state == IDLE && state_next == BUSY_D) begin
                last_d        <= 1'b1;
                d_grant_count <= d_grant_count + CNT_WIDTH'(1);
            end
            if (WD_EN && busy && state_next != IDLE) begin
                wdog <= wdog + WD_W'(1);
            end else begin
                wdog <= '0;
            end
        end
    end

endmodule

// File: tb/tb_memory_wishbone_arbiter.sv
// tb/tb_memory_wishbone_arbiter.sv - directed and randomized bench for memory_wishbone_arbiter
module tb_memory_wishbone_arbiter;

    localparam int DW = 128;
    localparam int AW = 12;
    localparam int SW = 16;
    localparam int TO = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          i_cyc, i_stb, i_we, d_cyc, d_stb, d_we;
    logic [SW-1:0] i_sel, d_sel, s_sel;
    logic [AW-1:0] i_adr, d_adr, s_adr;
    logic [DW-1:0] i_dat_m, d_dat_m, i_dat_s, d_dat_s, s_dat_m, s_dat_s;
    logic          i_ack, i_rty, d_ack, d_rty;
    logic          s_cyc, s_stb, s_we, s_ack, s_rty;
    logic          grant_i, grant_d, timeout_err;
    logic [CW-1:0] i_grant_count, d_grant_count;

    memory_wishbone_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW), .TIMEOUT(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_sel(i_sel), .i_adr(i_adr),
        .i_dat_m(i_dat_m), .i_dat_s(i_dat_s), .i_ack(i_ack), .i_rty(i_rty),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_sel(d_sel), .d_adr(d_adr),
        .d_dat_m(d_dat_m), .d_dat_s(d_dat_s), .d_ack(d_ack), .d_rty(d_rty),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
        .s_dat_m(s_dat_m), .s_dat_s(s_dat_s), .s_ack(s_ack), .s_rty(s_rty),
        .grant_i(grant_i), .grant_d(grant_d), .timeout_err(timeout_err),
        .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner 0 = none, 1 = I, 2 = D; age = cycles spent owned.
    int            m_owner;
    int            m_last;
    int            m_age;
    logic [CW-1:0] m_cnt_i;
    logic [CW-1:0] m_cnt_d;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_expired();
        return (m_owner != 0) && (m_age == TO) && !s_ack && !s_rty;
    endfunction

    task automatic randomize_data();
        i_sel   = SW'($urandom);
        d_sel   = SW'($urandom);
        i_dat_m = {$urandom, $urandom, $urandom, $urandom};
        d_dat_m = {$urandom, $urandom, $urandom, $urandom};
        s_dat_s = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic eval();
        logic          xc, xs, xw, ex;
        logic [SW-1:0] xsel;
        logic [AW-1:0] xa;
        logic [DW-1:0] xd;
        logic [37:0]   ctrl_exp;
        #1;
        ex = m_expired();
        {xc, xs, xw, xsel, xa, xd} = '0;
        if (m_owner == 1) {xc, xs, xw, xsel, xa, xd} = {i_cyc, i_stb, i_we, i_sel, i_adr, i_dat_m};
        if (m_owner == 2) {xc, xs, xw, xsel, xa, xd} = {d_cyc, d_stb, d_we, d_sel, d_adr, d_dat_m};
        ctrl_exp = {xc & ~ex, xs & ~ex, xw, xsel, xa,
                    (m_owner == 1) && s_ack, (m_owner == 1) && (s_rty || ex),
                    (m_owner == 2) && s_ack, (m_owner == 2) && (s_rty || ex),
                    m_owner == 1, m_owner == 2, ex};
        chk("ctrl", {s_cyc, s_stb, s_we, s_sel, s_adr, i_ack, i_rty, d_ack, d_rty,
                     grant_i, grant_d, timeout_err}, ctrl_exp);
        chk("s_dat_m", s_dat_m, xd);
        chk("counts", {i_grant_count, d_grant_count}, {m_cnt_i, m_cnt_d});
        if (m_owner == 1) chk("i_dat_s", i_dat_s, s_dat_s);
        else if (m_owner == 2) chk("d_dat_s", d_dat_s, s_dat_s);
    endtask

    task automatic tick();
        int            n_owner, n_last, n_age, w;
        logic [CW-1:0] ni, nd;
        logic          xc;
        n_owner = m_owner; n_last = m_last; n_age = m_age; ni = m_cnt_i; nd = m_cnt_d; w = 0;
        if (m_owner == 0) begin
            if ((i_cyc && i_stb) && (d_cyc && d_stb)) w = 3 - m_last;
            else if (i_cyc && i_stb) w = 1;
            else if (d_cyc && d_stb) w = 2;
            if (w != 0) begin
                n_owner = w; n_last = w; n_age = 0;
                if (w == 1) ni = ni + 1'b1; else nd = nd + 1'b1;
            end
        end else begin
            xc = (m_owner == 1) ? i_cyc : d_cyc;
            if (!xc || s_ack || s_rty || m_expired()) begin
                n_owner = 0; n_age = 0;
            end else begin
                n_age = m_age + 1;
            end
        end
        @(posedge clk);
        #1;
        m_owner = n_owner; m_last = n_last; m_age = n_age; m_cnt_i = ni; m_cnt_d = nd;
        randomize_data();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m_owner = 0; m_last = 1; m_age = 0; m_cnt_i = '0; m_cnt_d = '0;
        eval();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic drive_i(input logic cyc, input logic stb, input logic we, input logic [AW-1:0] adr);
        i_cyc = cyc; i_stb = stb; i_we = we; i_adr = adr;
    endtask

    task automatic drive_d(input logic cyc, input logic stb, input logic we, input logic [AW-1:0] adr);
        d_cyc = cyc; d_stb = stb; d_we = we; d_adr = adr;
    endtask

    initial begin
        reset_n = 1'b0;
        drive_i(0, 0, 0, '0);
        drive_d(0, 0, 0, '0);
        s_ack = 1'b0; s_rty = 1'b0;
        randomize_data();
        do_reset();

        // Single read, slave acks three cycles after s_cyc rises
        drive_i(1, 1, 0, 12'h040);
        eval(); chk("t1_idle_scyc", s_cyc, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            s_ack = (k == 3);
            eval();
            chk("t1_scyc", s_cyc, 1'b1);
            chk("t1_adr", s_adr, 12'h040);
            chk("t1_iack", i_ack, k == 3);
            tick();
        end
        s_ack = 1'b0;
        drive_i(0, 0, 0, '0);
        eval(); chk("t1_icnt", i_grant_count, 16'd1);
        tick();

        // Simultaneous requests out of reset: D first, then I
        do_reset();
        drive_i(1, 1, 0, 12'h111);
        drive_d(1, 1, 1, 12'h222);
        eval(); tick();
        s_ack = 1'b1;
        eval();
        chk("t2_grant_d", {grant_i, grant_d}, 2'b01);
        chk("t2_d_fields", {s_we, s_adr}, {1'b1, 12'h222});
        tick();
        eval(); tick();
        eval(); chk("t2_grant_i", {grant_i, grant_d}, 2'b10);
        tick();
        drive_i(0, 0, 0, '0); drive_d(0, 0, 0, '0); s_ack = 1'b0;
        eval(); chk("t2_counts", {i_grant_count, d_grant_count}, {16'd1, 16'd1});
        tick();

        // Continuous contention: six alternating grants
        do_reset();
        drive_i(1, 1, 0, 12'h0a0);
        drive_d(1, 1, 0, 12'h0d0);
        s_ack = 1'b1;
        for (int k = 0; k < 12; k++) begin
            eval();
            if (k % 2 == 1) chk("t3_grant", {grant_i, grant_d}, (k % 4 == 1) ? 2'b01 : 2'b10);
            chk("t3_exclusive", grant_i & grant_d, 1'b0);
            tick();
        end
        drive_i(0, 0, 0, '0); drive_d(0, 0, 0, '0); s_ack = 1'b0;
        eval(); chk("t3_counts", {i_grant_count, d_grant_count}, {16'd3, 16'd3});
        tick();

        // Abort by D with I pending
        drive_i(1, 1, 0, 12'h300);
        drive_d(1, 1, 0, 12'h400);
        eval(); tick();
        eval(); chk("t4_grant_d", {grant_i, grant_d}, 2'b01);
        tick();
        d_cyc = 1'b0;
        eval(); chk("t4_abort_scyc", s_cyc, 1'b0);
        tick();
        eval(); chk("t4_idle", {grant_i, grant_d}, 2'b00);
        tick();
        s_ack = 1'b1;
        eval(); chk("t4_grant_i", {grant_i, grant_d}, 2'b10);
        tick();
        drive_i(0, 0, 0, '0); drive_d(0, 0, 0, '0); s_ack = 1'b0;
        eval(); tick();

        // Watchdog expiry on a silent slave, then a normal transaction
        drive_i(1, 1, 1, 12'h555);
        eval(); tick();
        for (int n = 0; n <= TO; n++) begin
            eval();
            chk("t5_irty", i_rty, n == TO);
            chk("t5_terr", timeout_err, n == TO);
            chk("t5_scyc", s_cyc, n != TO);
            if (n == TO) i_cyc = 1'b0;
            tick();
        end
        eval(); chk("t5_after", {grant_i, timeout_err}, 2'b00);
        drive_i(1, 1, 0, 12'h556);
        tick();
        s_ack = 1'b1;
        eval(); chk("t5_normal", {i_ack, timeout_err}, 2'b10);
        tick();
        drive_i(0, 0, 0, '0); s_ack = 1'b0;
        eval(); tick();

        // Reset pulsed during BUSY_D
        drive_d(1, 1, 0, 12'h777);
        eval(); tick();
        eval(); chk("t6_busy_d", grant_d, 1'b1);
        do_reset();
        chk("t6_scyc_after", s_cyc, 1'b0);
        drive_i(1, 1, 0, 12'h778);
        eval(); tick();
        eval(); chk("t6_tie_d", {grant_i, grant_d}, 2'b01);
        tick();
        drive_i(0, 0, 0, '0); drive_d(0, 0, 0, '0);
        eval(); tick();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            i_cyc = ($urandom % 4) != 0;
            i_stb = ($urandom % 4) != 0;
            i_we  = 1'($urandom % 2);
            i_adr = AW'($urandom);
            d_cyc = ($urandom % 4) != 0;
            d_stb = ($urandom % 4) != 0;
            d_we  = 1'($urandom % 2);
            d_adr = AW'($urandom);
            s_ack = ($urandom % 3) == 0;
            s_rty = ($urandom % 10) == 0;
            eval();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
